cache_fill_responder: RTL and testbench

- Main-memory responder at the far end of the cache-miss interface; the cache fill FSM is the initiator.
- Accepts one request at a time from the data-side or instruction-side miss handler:
  - single-word write-through stores;
  - block-fill reads.
- A fill returns all 8 words of the 16-byte block, one word per cycle, after a fixed access latency.
- Models the multi-cycle memory that the pipeline stall logic (cstall) waits on.

---
 rtl/cache_fill_responder_pkg.sv | 15 +
 rtl/cache_fill_responder_mem_word_array.sv | 25 ++
 rtl/cache_fill_responder.sv | 129 ++++++++++++
 tb/tb_cache_fill_responder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_fill_responder_pkg.sv
// Shared types and constants for the cache fill responder.
// State encoding plus the block geometry that fills are built around.
package cache_fill_responder_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StWait   = 2'd1,
        StStream = 2'd2
    } state_e;

    localparam int unsigned WORDS_PER_BLOCK   = 8;
    localparam int unsigned BLOCK_OFFSET_BITS = 4;
    localparam int unsigned IDX_W             = 3;

endpackage

// File: rtl/cache_fill_responder_mem_word_array.sv
// Word-wide storage array: one synchronous write port, one combinational read port.
// Deliberately has no reset so contents survive a responder reset.
module mem_word_array #(
    parameter int unsigned AW = 15,
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [1 << AW];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/cache_fill_responder.sv
// Main-memory responder for cache misses: accepts single-word writes and
// block-fill reads, returning an aligned 8-word block after a fixed latency.
module cache_fill_responder
    import cache_fill_responder_pkg::*;
#(
    parameter int unsigned ADDR_W          = 16,
    parameter int unsigned DEPTH_LOG2      = 15,
    parameter int unsigned LATENCY         = 4,
    parameter int unsigned WORDS_PER_BLOCK = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_write,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [15:0]       i_req_wdata,
    output logic              o_rsp_valid,
    output logic [15:0]       o_rsp_data,
    output logic [IDX_W-1:0]  o_rsp_word,
    output logic              o_rsp_last,
    output logic              o_busy
);

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(WORDS_PER_BLOCK - 1);

    state_e                              r_state;
    logic [3:0]                          r_cnt;
    logic [IDX_W-1:0]                    r_idx;
    logic [ADDR_W-BLOCK_OFFSET_BITS-1:0] r_blk;
    logic                                r_req_ready;
    logic                                r_rsp_valid;
    logic [15:0]                         r_rsp_data;
    logic                                r_rsp_last;
    logic                                r_busy;

    logic                  w_we;
    logic [IDX_W-1:0]      w_rd_idx;
    logic [ADDR_W-2:0]     w_rd_word;
    logic [DEPTH_LOG2-1:0] w_raddr;
    logic [15:0]           w_rd_data;
    logic                  w_unused;

    assign w_we      = i_req_valid & i_req_write & r_req_ready;
    // Read address is for the word being presented after the coming edge.
    assign w_rd_idx  = (r_state == StStream) ? r_idx + 3'd1 : '0;
    assign w_rd_word = {r_blk, w_rd_idx};
    assign w_raddr   = w_rd_word[DEPTH_LOG2-1:0];
    assign w_unused  = i_req_addr[0];

    mem_word_array #(
        .AW (DEPTH_LOG2),
        .DW (16)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (i_req_addr[DEPTH_LOG2:1]),
        .i_wdata (i_req_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_blk       <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_last  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_req_valid && !i_req_write) begin
                        r_blk       <= i_req_addr[ADDR_W-1:BLOCK_OFFSET_BITS];
                        r_cnt       <= 4'(LATENCY - 1);
                        r_state     <= StWait;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                StWait: begin
                    if (r_cnt == 4'd0) begin
                        r_state     <= StStream;
                        r_idx       <= '0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= w_rd_data;
                        r_rsp_last  <= (LastIdx == '0);
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                StStream: begin
                    if (r_idx == LastIdx) begin
                        r_state     <= StIdle;
                        r_idx       <= '0;
                        r_rsp_valid <= 1'b0;
                        r_rsp_data  <= '0;
                        r_rsp_last  <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end else begin
                        r_idx      <= w_rd_idx;
                        r_rsp_data <= w_rd_data;
                        r_rsp_last <= (w_rd_idx == LastIdx);
                    end
                end
                default: begin
                    r_state     <= StIdle;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_rsp_last  <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign o_req_ready = r_req_ready;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_word  = r_idx;
    assign o_rsp_last  = r_rsp_last;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_cache_fill_responder.sv
// Self-checking bench for cache_fill_responder: a cycle-level behavioural
// model of the fill timeline checked every cycle, plus literal data pins.
module tb_cache_fill_responder;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic [2:0]  rsp_word;
    logic        rsp_last;
    logic        busy;

    always #5 clk = ~clk;

    cache_fill_responder #(
        .ADDR_W          (16),
        .DEPTH_LOG2      (15),
        .LATENCY         (LAT),
        .WORDS_PER_BLOCK (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_write (req_write),
        .i_req_addr  (req_addr),
        .i_req_wdata (req_wdata),
        .o_rsp_valid (rsp_valid),
        .o_rsp_data  (rsp_data),
        .o_rsp_word  (rsp_word),
        .o_rsp_last  (rsp_last),
        .o_busy      (busy)
    );

    int total = 0;
    int bad = 0;

    // Model state: word-addressed memory and the current fill's timeline.
    logic [15:0] mm [int];
    int          cyc = 0;
    bit          active = 1'b0;
    int          acc = 0;
    int          base_w = 0;
    int          acc_cnt = 0;
    logic [15:0] cap [8];
    logic [15:0] saved [8];
    int          first_v = -1;
    int          last_v = -1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit rdy;
        cyc++;
        if (rst_n) begin
            rdy = !active;
            if (active && (cyc - acc) >= LAT + 8) active = 1'b0;
            if (rdy && req_valid) begin
                acc_cnt++;
                if (req_write) begin
                    mm[int'(req_addr[15:1])] = req_wdata;
                end else begin
                    active  = 1'b1;
                    acc     = cyc;
                    base_w  = int'(req_addr[15:4]) * 8;
                    first_v = -1;
                end
            end
        end
    end

    always @(negedge rst_n) active = 1'b0;

    always @(negedge clk) begin
        int  k;
        bit  ev;
        if (!rst_n) begin
            chk("rst_ready", 32'(req_ready), 32'd1);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_valid", 32'(rsp_valid), 32'd0);
            chk("rst_data", 32'(rsp_data), 32'd0);
            chk("rst_word", 32'(rsp_word), 32'd0);
            chk("rst_last", 32'(rsp_last), 32'd0);
        end else begin
            k  = cyc - acc;
            ev = active && k >= LAT && k < LAT + 8;
            chk("req_ready", 32'(req_ready), 32'(!active));
            chk("busy", 32'(busy), 32'(active));
            chk("rsp_valid", 32'(rsp_valid), 32'(ev));
            if (ev) begin
                chk("rsp_word", 32'(rsp_word), 32'(k - LAT));
                chk("rsp_data", 32'(rsp_data), 32'(mm[base_w + (k - LAT)]));
                chk("rsp_last", 32'(rsp_last), 32'((k - LAT) == 7));
                cap[k - LAT] = rsp_data;
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
            end else begin
                chk("rsp_last_idle", 32'(rsp_last), 32'd0);
            end
        end
    end

    task automatic issue(input bit wr, input logic [15:0] a, input logic [15:0] d);
        int n0;
        int t;
        n0 = acc_cnt;
        t = 0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        while (acc_cnt == n0 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (acc_cnt == n0) chk("accept_timeout", 32'd0, 32'd1);
        req_valid = 1'b0;
        req_write = 1'b0;
    endtask

    task automatic wait_fill();
        int t;
        t = 0;
        while (active && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (active) chk("fill_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic fill with pre-written block 0x0010.
        issue(1'b1, 16'h0010, 16'h1111);
        for (int i = 1; i < 7; i++) issue(1'b1, 16'(16'h0010 + 2 * i), 16'h0000);
        issue(1'b1, 16'h001E, 16'hAAAA);
        issue(1'b0, 16'h0014, 16'h0000);
        wait_fill();
        chk("t1_w0", 32'(cap[0]), 32'h1111);
        chk("t1_w3", 32'(cap[3]), 32'h0000);
        chk("t1_w7", 32'(cap[7]), 32'hAAAA);
        chk("t1_first_beat_lat", 32'(first_v - acc), 32'd4);
        chk("t1_last_beat_lat", 32'(last_v - acc), 32'd11);

        // Write held during a fill is not accepted until the fill ends.
        issue(1'b0, 16'h0010, 16'h0000);
        issue(1'b1, 16'h0012, 16'h5A5A);
        chk("t3_old_w1", 32'(cap[1]), 32'h0000);
        issue(1'b0, 16'h001A, 16'h0000);
        wait_fill();
        chk("t3_new_w1", 32'(cap[1]), 32'h5A5A);
        chk("t3_new_w0", 32'(cap[0]), 32'h1111);

        // Top-of-memory block: no wrap into word 0.
        issue(1'b1, 16'h0000, 16'h1234);
        for (int i = 0; i < 7; i++) issue(1'b1, 16'(16'hFFF0 + 2 * i), 16'(16'hC000 + i));
        issue(1'b1, 16'hFFFE, 16'hBEEF);
        issue(1'b0, 16'hFFF7, 16'h0000);
        wait_fill();
        chk("t4_w0", 32'(cap[0]), 32'hC000);
        chk("t4_w7", 32'(cap[7]), 32'hBEEF);

        // Reset mid-stream after the third beat.
        issue(1'b0, 16'h0010, 16'h0000);
        for (int i = 0; i < 8; i++) saved[i] = mm[8 + i];
        repeat (6) @(posedge clk);
        #3;
        chk("t5_pre_valid", 32'(rsp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_valid", 32'(rsp_valid), 32'd0);
        chk("t5_last", 32'(rsp_last), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(1'b0, 16'h0018, 16'h0000);
        wait_fill();
        for (int i = 0; i < 8; i++) chk("t5_refill", 32'(cap[i]), 32'(saved[i]));
        chk("t5_w1", 32'(cap[1]), 32'h5A5A);

        // Back-to-back writes (odd addresses included) then immediate read.
        for (int i = 4; i < 8; i++) issue(1'b1, 16'(16'h0040 + 2 * i), 16'h0000);
        issue(1'b1, 16'h0041, 16'h0A0A);
        issue(1'b1, 16'h0042, 16'h0B0B);
        issue(1'b1, 16'h0045, 16'h0C0C);
        issue(1'b1, 16'h0046, 16'h0D0D);
        issue(1'b0, 16'h0040, 16'h0000);
        chk("t6_busy_after_read", 32'(busy), 32'd1);
        wait_fill();
        chk("t6_w0", 32'(cap[0]), 32'h0A0A);
        chk("t6_w1", 32'(cap[1]), 32'h0B0B);
        chk("t6_w2", 32'(cap[2]), 32'h0C0C);
        chk("t6_w3", 32'(cap[3]), 32'h0D0D);
        chk("t6_w4", 32'(cap[4]), 32'h0000);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
